dmem_arbiter: RTL and testbench

//  Two-master arbiter for the data-memory/IO bus that sits between the CPU data port and MIOC.
//  - Master 0 is the CPU memory stage and has priority.
//  - Master 1 is a secondary requester (DMA/loader) using a req/gnt handshake with optional burst lock.
//  - Stalls the CPU while master 1 owns the bus; bounds CPU hogging and master-1 bursts with hold counters.

---
 rtl/dmem_arbiter.sv | 120 ++++++++++++
 tb/tb_dmem_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the data-memory/IO bus: CPU (M0, priority) and a req/gnt secondary master (M1).
// Optional macro STARVE_GUARD_EN adds a hold counter that forces M1 in after MAX_HOLD contended cycles.
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_ce,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_stall,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              bus_ce,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              owner
);

  localparam int unsigned LOCK_W = $clog2(MAX_LOCK) + 1;

  if (MAX_HOLD < 2 || MAX_LOCK < 2) begin : g_param_check
    $error("dmem_arbiter: MAX_HOLD and MAX_LOCK must be >= 2");
  end

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } own_e;

  own_e              owner_q;
  logic [LOCK_W-1:0] lock_cnt_q;
  logic              own_m1;
  logic              starve;
  logic              lock_max;
  logic              take_m1;
  logic              release_m1;

  assign own_m1   = (owner_q == OWN_M1);
  assign lock_max = (lock_cnt_q == LOCK_W'(MAX_LOCK - 1));

  // M1 enters on an idle CPU cycle (or when the CPU has hogged the bus too long)
  assign take_m1    = m1_req && (!m0_ce || starve);
  // M1 leaves when done, after a single unlocked access, or when its lock budget runs out
  assign release_m1 = !m1_req || (m0_ce && (!m1_lock || lock_max));

`ifdef STARVE_GUARD_EN
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD) + 1;

  logic [HOLD_W-1:0] hold_cnt_q;

  assign starve = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));

  // Counts contended cycles that M0 keeps the bus while M1 waits
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q <= '0;
    end else if (own_m1 || !m1_req || take_m1) begin
      hold_cnt_q <= '0;
    end else if (!starve) begin
      hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
    end
  end
`else
  assign starve = 1'b0;
`endif

  // Ownership state and M1 burst-length counter
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q    <= OWN_M0;
      lock_cnt_q <= '0;
    end else begin
      case (owner_q)
        OWN_M0: begin
          lock_cnt_q <= '0;
          if (take_m1) begin
            owner_q <= OWN_M1;
          end
        end
        OWN_M1: begin
          if (release_m1) begin
            owner_q    <= OWN_M0;
            lock_cnt_q <= '0;
          end else if (m0_ce) begin
            lock_cnt_q <= lock_cnt_q + LOCK_W'(1);
          end
        end
        default: begin
          owner_q    <= OWN_M0;
          lock_cnt_q <= '0;
        end
      endcase
    end
  end

  // Datapath steering follows the ownership register combinationally
  assign bus_ce    = own_m1 ? m1_req   : m0_ce;
  assign bus_we    = own_m1 ? m1_we    : m0_we;
  assign bus_addr  = own_m1 ? m1_addr  : m0_addr;
  assign bus_wdata = own_m1 ? m1_wdata : m0_wdata;
  assign m0_rdata  = own_m1 ? '0 : bus_rdata;
  assign m1_rdata  = own_m1 ? bus_rdata : '0;
  assign m0_stall  = own_m1 && m0_ce;
  assign m1_gnt    = own_m1 && m1_req;
  assign owner     = own_m1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a cycle-level reference of the arbitration rules predicts every
// output; a negedge monitor pops and compares. Honors STARVE_GUARD_EN like the design.
module tb_dmem_arbiter;
  localparam int unsigned AW       = 32;
  localparam int unsigned DW       = 32;
  localparam int unsigned MAX_HOLD = 8;
  localparam int unsigned MAX_LOCK = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_ce, m0_we, m0_stall;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_lock, m1_gnt;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          bus_ce, bus_we, owner;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata, bus_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MAX_HOLD), .MAX_LOCK(MAX_LOCK)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_ce(m0_ce), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_stall(m0_stall),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rdata(m1_rdata),
    .bus_ce(bus_ce), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .owner(owner)
  );

  function automatic logic [DW-1:0] pat(input int i);
    return 32'hC0DE_0000 + DW'(i * 7);
  endfunction

  // Slave RAM on the bus: combinational read, write on the edge, refilled by reset
  logic [DW-1:0] ram [256];
  assign bus_rdata = ram[bus_addr[7:0]];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) ram[i] <= pat(i);
    end else if (bus_ce && bus_we) begin
      ram[bus_addr[7:0]] <= bus_wdata;
    end
  end

  typedef struct packed {
    logic          own;
    logic          gnt;
    logic          stall;
    logic          ce;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] r0;
    logic [DW-1:0] r1;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference: who owns the bus, how many contended cycles M0 has kept it, how long M1's burst has run
  bit            m_m1_owns = 1'b0;
  int            m_waited  = 0;
  int            m_burst   = 0;
  logic [DW-1:0] ref_ram [256];
  bit            last_gnt  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("owner",     64'(owner),     64'(e.own));
      chk("m1_gnt",    64'(m1_gnt),    64'(e.gnt));
      chk("m0_stall",  64'(m0_stall),  64'(e.stall));
      chk("bus_ce",    64'(bus_ce),    64'(e.ce));
      chk("bus_we",    64'(bus_we),    64'(e.we));
      chk("bus_addr",  64'(bus_addr),  64'(e.addr));
      chk("bus_wdata", 64'(bus_wdata), 64'(e.wdata));
      chk("m0_rdata",  64'(m0_rdata),  64'(e.r0));
      chk("m1_rdata",  64'(m1_rdata),  64'(e.r1));
    end
  end

  // Drive one cycle of inputs, predict the outputs, then advance the reference to the next edge
  task automatic cycle(input logic r, input logic c0, input logic w0, input logic [7:0] a0,
                       input logic [DW-1:0] d0, input logic q1, input logic w1, input logic l1,
                       input logic [7:0] a1, input logic [DW-1:0] d1);
    exp_t e;
    bit   starve;
    @(posedge clk);
    #1;
    rst = r; m0_ce = c0; m0_we = w0; m0_addr = AW'(a0); m0_wdata = d0;
    m1_req = q1; m1_we = w1; m1_lock = l1; m1_addr = AW'(a1); m1_wdata = d1;

    e.own = m_m1_owns;
    if (!m_m1_owns) begin
      e.ce = c0; e.we = w0; e.addr = AW'(a0); e.wdata = d0;
      e.r0 = ref_ram[a0]; e.r1 = '0; e.stall = 1'b0; e.gnt = 1'b0;
    end else begin
      e.ce = q1; e.we = w1; e.addr = AW'(a1); e.wdata = d1;
      e.r0 = '0; e.r1 = ref_ram[a1]; e.stall = c0; e.gnt = q1;
    end
    exp_q.push_back(e);
    last_gnt = e.gnt;

`ifdef STARVE_GUARD_EN
    starve = (m_waited >= MAX_HOLD - 1);
`else
    starve = 1'b0;
`endif
    if (r) begin
      for (int i = 0; i < 256; i++) ref_ram[i] = pat(i);
      m_m1_owns = 1'b0; m_waited = 0; m_burst = 0;
    end else begin
      if (e.ce && e.we) ref_ram[e.addr[7:0]] = e.wdata;
      if (!m_m1_owns) begin
        m_burst = 0;
        if (q1 && (!c0 || starve)) begin
          m_m1_owns = 1'b1; m_waited = 0;
        end else if (!q1) begin
          m_waited = 0;
        end else begin
          m_waited++;
        end
      end else begin
        m_waited = 0;
        if (!q1 || (c0 && !l1) || (c0 && m_burst == MAX_LOCK - 1)) begin
          m_m1_owns = 1'b0; m_burst = 0;
        end else if (c0) begin
          m_burst++;
        end
      end
    end
  endtask

  initial begin
    logic [7:0]    ra0, ra1;
    logic [DW-1:0] rd0, rd1;
    logic          rw1, pend;

    rst = 1'b1; m0_ce = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = '0; m1_wdata = '0;
    for (int i = 0; i < 256; i++) ref_ram[i] = pat(i);
    @(posedge clk);

    // Reset, bus follows the CPU
    repeat (2) cycle(1, 0, 0, 8'h10, 0, 0, 0, 0, 8'h00, 0);
    cycle(0, 1, 0, 8'h10, 0, 0, 0, 0, 8'h00, 0);

    // Single M1 write with an idle CPU, then release
    repeat (2) cycle(0, 0, 0, 8'h10, 0, 1, 1, 0, 8'h40, 32'h0000_A5A5);
    cycle(0, 0, 0, 8'h10, 0, 0, 0, 0, 8'h40, 0);
    chk("ram_0x40", 64'(ram[8'h40]), 64'(32'h0000_A5A5));
    cycle(0, 1, 0, 8'h40, 0, 0, 0, 0, 8'h00, 0);

    // Locked burst of 4 with the CPU waiting, last access unlocked
    cycle(0, 0, 0, 8'h20, 0, 1, 0, 1, 8'h50, 32'h1111);
    for (int i = 0; i < 4; i++)
      cycle(0, 1, 0, 8'h20, 0, 1, 0, (i < 3) ? 1'b1 : 1'b0, 8'(8'h50 + i), 0);
    repeat (2) cycle(0, 1, 0, 8'h20, 0, 0, 0, 0, 8'h00, 0);

    // Sustained contention, then CPU goes idle
    for (int i = 0; i < 50; i++) cycle(0, 1, 0, 8'(i), 0, 1, 0, 0, 8'h60, 0);
    repeat (2) cycle(0, 0, 0, 8'h00, 0, 1, 0, 0, 8'h60, 0);
    cycle(0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0);

    // Lock budget exhaustion, then reset during a burst
    cycle(0, 0, 0, 8'h00, 0, 1, 1, 1, 8'h70, 32'h7777);
    for (int i = 0; i < 20; i++) cycle(0, 1, 0, 8'h01, 0, 1, 1, 1, 8'(8'h70 + i), DW'(i));
    cycle(0, 1, 0, 8'h01, 0, 0, 0, 0, 8'h00, 0);
    cycle(0, 0, 0, 8'h00, 0, 1, 0, 1, 8'h80, 0);
    repeat (3) cycle(0, 1, 0, 8'h02, 0, 1, 0, 1, 8'h80, 0);
    cycle(1, 1, 0, 8'h02, 0, 1, 0, 1, 8'h80, 0);
    repeat (2) cycle(0, 1, 0, 8'h02, 0, 1, 0, 1, 8'h80, 0);
    cycle(0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0);

    // Randomized traffic; M1 holds its request until granted
    pend = 1'b0; ra1 = '0; rd1 = '0; rw1 = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!pend || last_gnt) begin
        pend = ($urandom_range(2, 0) != 0);
        ra1  = 8'($urandom); rd1 = $urandom; rw1 = 1'($urandom);
      end
      ra0 = 8'($urandom); rd0 = $urandom;
      cycle(($urandom_range(399, 0) == 0), ($urandom_range(9, 0) < 7), 1'($urandom), ra0, rd0,
            pend, rw1, ($urandom_range(3, 0) != 0), ra1, rd1);
    end
    cycle(0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
